// File: rtl/qpsk_pkg.sv
// Shared types and defaults for the QPSK symbol framer and its pair FIFO.
package qpsk_pkg;

   // Default framing parameters: one carrier period per symbol, four buffered pairs.
   localparam int DEF_CYCLES_PER_SYM = 16;
   localparam int DEF_FIFO_DEPTH     = 4;
   localparam int DEF_CNT_W          = 4;

   // Presentation state: waiting for a pair, or presenting a symbol.
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // One QPSK symbol: even (I) bit in the MSB, odd (Q) bit in the LSB.
   typedef struct packed {
      logic eve;
      logic odd;
   } sym_pair_t;

   // Builds a pair from the two serial bits in arrival order.
   function automatic sym_pair_t make_pair(input logic first_bit, input logic second_bit);
      sym_pair_t p;
      p.eve = first_bit;
      p.odd = second_bit;
      return p;
   endfunction

endpackage

// File: rtl/qpsk_pair_fifo.sv
// Small synchronous FIFO of symbol pairs with full/empty flags.
// The read port is combinational from the storage array so that the pair at
// the head is available in the same cycle the pop is decided; there is no
// fall-through, a pushed pair becomes visible at the head one cycle later.
// A push while full is accepted only when a pop happens in the same cycle.
module qpsk_pair_fifo
   import qpsk_pkg::*;
#(
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic [1:0] push_data,
   input  logic       pop,
   output logic [1:0] pop_data,
   output logic       full,
   output logic       empty
);

   localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   logic [1:0]    mem_reg [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic          do_push;
   logic          do_pop;

   assign empty    = (count_reg == '0);
   assign full     = (count_reg == FULL_COUNT);
   assign do_pop   = pop && !empty;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem_reg[rd_ptr_reg];

   // Storage write; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_reg[wr_ptr_reg] <= push_data;
      end
   end

   // Pointer and occupancy tracking; depth is a power of two so pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         if (do_push && !do_pop) begin
            count_reg <= count_reg + 1'b1;
         end else if (do_pop && !do_push) begin
            count_reg <= count_reg - 1'b1;
         end
      end
   end

endmodule

// File: rtl/qpsk_symbol_framer.sv
// Serial-bit to QPSK symbol framer.
// Bits arrive over a valid/ready handshake and are paired (first = even/I,
// second = odd/Q). Completed pairs are buffered and each is presented as
// steady dataeve/dataodd levels for exactly CYCLES_PER_SYM clocks, with a
// next1 strobe on the first cycle of a symbol and next2 at the half-symbol
// point. When a symbol ends with nothing buffered, underrun pulses and the
// framer goes idle, holding the last data levels.
module qpsk_symbol_framer
   import qpsk_pkg::*;
#(
   parameter int CYCLES_PER_SYM = DEF_CYCLES_PER_SYM,
   parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
   parameter int CNT_W          = DEF_CNT_W
) (
   input  logic clk,
   input  logic reset,
   input  logic bit_in,
   input  logic bit_valid,
   output logic bit_ready,
   output logic dataeve,
   output logic dataodd,
   output logic next1,
   output logic next2,
   output logic sym_active,
   output logic underrun
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYCLES_PER_SYM - 1);
   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CYCLES_PER_SYM / 2);

   // Pair assembly
   logic      even_reg;
   logic      half_flag_reg;
   logic      bit_accept;

   // FIFO interface
   logic      fifo_push;
   logic      fifo_pop;
   logic      fifo_full;
   logic      fifo_empty;
   sym_pair_t fifo_wdata;
   sym_pair_t fifo_rdata;

   // Presentation state and registered outputs
   state_t           state_reg,      state_next;
   logic [CNT_W-1:0] cnt_reg,        cnt_next;
   logic [CNT_W-1:0] cnt_inc;
   logic             dataeve_reg,    dataeve_next;
   logic             dataodd_reg,    dataodd_next;
   logic             next1_reg,      next1_next;
   logic             next2_reg,      next2_next;
   logic             sym_active_reg, sym_active_next;
   logic             underrun_next;

   // The first bit of a pair may always be taken; the second bit stalls only
   // when the pair it completes would have nowhere to go.
   assign bit_ready  = !reset && !(fifo_full && half_flag_reg);
   assign bit_accept = bit_valid && bit_ready;
   assign fifo_push  = bit_accept && half_flag_reg;
   assign fifo_wdata = make_pair(even_reg, bit_in);

   // Latch the even bit and track whether a pair is half built.
   always_ff @(posedge clk) begin
      if (reset) begin
         even_reg      <= 1'b0;
         half_flag_reg <= 1'b0;
      end else if (bit_accept) begin
         if (!half_flag_reg) begin
            even_reg      <= bit_in;
            half_flag_reg <= 1'b1;
         end else begin
            half_flag_reg <= 1'b0;
         end
      end
   end

   qpsk_pair_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_pair_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (fifo_wdata),
      .pop       (fifo_pop),
      .pop_data  (fifo_rdata),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign cnt_inc = cnt_reg + 1'b1;

   // Next-state and next-output logic: start a symbol from idle, count through
   // it, then either chain straight into the next buffered pair or go idle.
   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      dataeve_next    = dataeve_reg;
      dataodd_next    = dataodd_reg;
      next1_next      = 1'b0;
      next2_next      = 1'b0;
      sym_active_next = sym_active_reg;
      underrun_next   = 1'b0;
      fifo_pop        = 1'b0;

      unique case (state_reg)
         IDLE: begin
            cnt_next        = '0;
            sym_active_next = 1'b0;
            if (!fifo_empty) begin
               fifo_pop        = 1'b1;
               dataeve_next    = fifo_rdata.eve;
               dataodd_next    = fifo_rdata.odd;
               next1_next      = 1'b1;
               sym_active_next = 1'b1;
               state_next      = RUN;
            end
         end

         RUN: begin
            if (cnt_reg == LAST_CNT) begin
               cnt_next = '0;
               if (!fifo_empty) begin
                  // Back-to-back symbol: no gap between the last and first cycle.
                  fifo_pop     = 1'b1;
                  dataeve_next = fifo_rdata.eve;
                  dataodd_next = fifo_rdata.odd;
                  next1_next   = 1'b1;
               end else begin
                  underrun_next   = 1'b1;
                  sym_active_next = 1'b0;
                  state_next      = IDLE;
               end
            end else begin
               cnt_next   = cnt_inc;
               // Registered, so the strobe is visible while the count sits at the half point.
               next2_next = (cnt_inc == HALF_CNT);
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, counter and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         dataeve_reg    <= 1'b0;
         dataodd_reg    <= 1'b0;
         next1_reg      <= 1'b0;
         next2_reg      <= 1'b0;
         sym_active_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         dataeve_reg    <= dataeve_next;
         dataodd_reg    <= dataodd_next;
         next1_reg      <= next1_next;
         next2_reg      <= next2_next;
         sym_active_reg <= sym_active_next;
      end
   end

   assign dataeve    = dataeve_reg;
   assign dataodd    = dataodd_reg;
   assign next1      = next1_reg;
   assign next2      = next2_reg;
   assign sym_active = sym_active_reg;
   // Marks the final cycle of a symbol that has no successor buffered.
   assign underrun   = underrun_next && !reset;

endmodule
